// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO controller with fill-level counter, almost-full/empty
// thresholds, synchronous flush, error pulses and registered or FWFT read port.
module sync_fifo_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 8,
    parameter int AF_THR     = FIFO_DEPTH - 1,
    parameter int AE_THR     = 1,
    parameter int FWFT       = 0,
    localparam int CW        = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush_i,
    input  logic                  w_incr_i,
    input  logic [DATA_WIDTH-1:0] w_data,
    output logic                  w_full_o,
    output logic                  w_almost_full_o,
    output logic                  w_overflow_o,
    input  logic                  r_incr_i,
    output logic [DATA_WIDTH-1:0] r_data,
    output logic                  r_valid_o,
    output logic                  r_empty_o,
    output logic                  r_almost_empty_o,
    output logic                  r_underflow_o,
    output logic [CW-1:0]         count_o
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [PW-1:0] PTR_LAST = PW'(FIFO_DEPTH - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] CNT_AF   = CW'(AF_THR);
    localparam logic [CW-1:0] CNT_AE   = CW'(AE_THR);

    logic [FIFO_DEPTH-1:0][DATA_WIDTH-1:0] mem_q, mem_d;
    logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d, udf_q, udf_d;
    logic          full, empty, w_acc, r_acc;

    // Explicit wrap so non-power-of-two depths work.
    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        full    = (count_q == CNT_FULL);
        empty   = (count_q == '0);
        w_acc   = w_incr_i & ~full & ~flush_i;
        r_acc   = r_incr_i & ~empty & ~flush_i;
        mem_d   = mem_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        ovf_d   = w_incr_i & full & ~flush_i;
        udf_d   = r_incr_i & empty & ~flush_i;
        if (w_acc) begin
            mem_d[wptr_q] = w_data;
            wptr_d        = ptr_next(wptr_q);
        end
        if (r_acc) rptr_d = ptr_next(rptr_q);
        case ({w_acc, r_acc})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        // Flush wins over any request; memory contents are left alone.
        if (flush_i) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_q   <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            mem_q   <= mem_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    assign w_full_o         = full;
    assign w_almost_full_o  = (count_q >= CNT_AF);
    assign w_overflow_o     = ovf_q;
    assign r_empty_o        = empty;
    assign r_almost_empty_o = (count_q <= CNT_AE);
    assign r_underflow_o    = udf_q;
    assign count_o          = count_q;

    generate
        if (FWFT != 0) begin : g_fwft
            assign r_data    = mem_q[rptr_q];
            assign r_valid_o = ~empty;
        end else begin : g_reg
            logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
            logic                  rvalid_q, rvalid_d;

            always_comb begin
                rvalid_d = r_acc;
                rdata_d  = r_acc ? mem_q[rptr_q] : rdata_q;
            end

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    rdata_q  <= '0;
                    rvalid_q <= 1'b0;
                end else begin
                    rdata_q  <= rdata_d;
                    rvalid_q <= rvalid_d;
                end
            end

            assign r_data    = rdata_q;
            assign r_valid_o = rvalid_q;
        end
    endgenerate

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Bench for sync_fifo_ctrl: three configurations share one stimulus stream and
// are checked every cycle against a list-based FIFO model plus literal spot checks.
module tb_sync_fifo_ctrl;

    logic clk = 1'b0;
    logic reset, flush, w_incr, r_incr;
    logic [7:0] wd;

    logic [2:0]      full_v, afull_v, ovf_v, rv_v, emp_v, aemp_v, udf_v;
    logic [2:0][7:0] rd_v;
    logic [2:0]      c0, c1;
    logic [3:0]      c2;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    sync_fifo_ctrl #(.DATA_WIDTH(8), .FIFO_DEPTH(5), .FWFT(0)) u0 (
        .clk(clk), .reset(reset), .flush_i(flush), .w_incr_i(w_incr), .w_data(wd),
        .w_full_o(full_v[0]), .w_almost_full_o(afull_v[0]), .w_overflow_o(ovf_v[0]),
        .r_incr_i(r_incr), .r_data(rd_v[0]), .r_valid_o(rv_v[0]), .r_empty_o(emp_v[0]),
        .r_almost_empty_o(aemp_v[0]), .r_underflow_o(udf_v[0]), .count_o(c0));

    sync_fifo_ctrl #(.DATA_WIDTH(8), .FIFO_DEPTH(5), .FWFT(1)) u1 (
        .clk(clk), .reset(reset), .flush_i(flush), .w_incr_i(w_incr), .w_data(wd),
        .w_full_o(full_v[1]), .w_almost_full_o(afull_v[1]), .w_overflow_o(ovf_v[1]),
        .r_incr_i(r_incr), .r_data(rd_v[1]), .r_valid_o(rv_v[1]), .r_empty_o(emp_v[1]),
        .r_almost_empty_o(aemp_v[1]), .r_underflow_o(udf_v[1]), .count_o(c1));

    sync_fifo_ctrl #(.DATA_WIDTH(8), .FIFO_DEPTH(8), .AF_THR(6), .AE_THR(2), .FWFT(0)) u2 (
        .clk(clk), .reset(reset), .flush_i(flush), .w_incr_i(w_incr), .w_data(wd),
        .w_full_o(full_v[2]), .w_almost_full_o(afull_v[2]), .w_overflow_o(ovf_v[2]),
        .r_incr_i(r_incr), .r_data(rd_v[2]), .r_valid_o(rv_v[2]), .r_empty_o(emp_v[2]),
        .r_almost_empty_o(aemp_v[2]), .r_underflow_o(udf_v[2]), .count_o(c2));

    function automatic int dep(int k);   return (k == 2) ? 8 : 5; endfunction
    function automatic int afthr(int k); return (k == 2) ? 6 : 4; endfunction
    function automatic int aethr(int k); return (k == 2) ? 2 : 1; endfunction
    function automatic bit is_fwft(int k); return k == 1; endfunction
    function automatic int cnt(int k);
        if (k == 0) return int'(c0);
        if (k == 1) return int'(c1);
        return int'(c2);
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: an ordered list of held words per instance, oldest at index 0.
    int         msz[3];
    logic [7:0] mdat[3][8];
    logic [7:0] mrd[3];
    bit         mrv[3], movf[3], mudf[3];

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < 3; k++) begin
                msz[k] = 0; mrd[k] = 8'h00; mrv[k] = 0; movf[k] = 0; mudf[k] = 0;
            end
        end else begin
            for (int k = 0; k < 3; k++) begin
                bit fl, em, wa, ra;
                fl = (msz[k] == dep(k));
                em = (msz[k] == 0);
                wa = w_incr && !fl && !flush;
                ra = r_incr && !em && !flush;
                movf[k] = w_incr && fl && !flush;
                mudf[k] = r_incr && em && !flush;
                mrv[k]  = ra;
                if (ra) begin
                    mrd[k] = mdat[k][0];
                    for (int j = 0; j < 7; j++) mdat[k][j] = mdat[k][j+1];
                    msz[k]--;
                end
                if (wa) begin
                    mdat[k][msz[k]] = wd;
                    msz[k]++;
                end
                if (flush) msz[k] = 0;
            end
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("u%0d count", k), cnt(k), msz[k]);
            chk($sformatf("u%0d full", k), int'(full_v[k]), int'(msz[k] == dep(k)));
            chk($sformatf("u%0d empty", k), int'(emp_v[k]), int'(msz[k] == 0));
            chk($sformatf("u%0d almost_full", k), int'(afull_v[k]), int'(msz[k] >= afthr(k)));
            chk($sformatf("u%0d almost_empty", k), int'(aemp_v[k]), int'(msz[k] <= aethr(k)));
            chk($sformatf("u%0d overflow", k), int'(ovf_v[k]), int'(movf[k]));
            chk($sformatf("u%0d underflow", k), int'(udf_v[k]), int'(mudf[k]));
            if (is_fwft(k)) begin
                chk($sformatf("u%0d r_valid", k), int'(rv_v[k]), int'(msz[k] > 0));
                if (msz[k] > 0) chk($sformatf("u%0d r_data", k), int'(rd_v[k]), int'(mdat[k][0]));
            end else begin
                chk($sformatf("u%0d r_valid", k), int'(rv_v[k]), int'(mrv[k]));
                if (mrv[k]) chk($sformatf("u%0d r_data", k), int'(rd_v[k]), int'(mrd[k]));
            end
        end
    end

    task automatic step(input bit w, input logic [7:0] d, input bit r, input bit f);
        w_incr = w; wd = d; r_incr = r; flush = f;
        @(negedge clk);
    endtask

    task automatic chk_reset(input string tag);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("%s u%0d count", tag, k), cnt(k), 0);
            chk($sformatf("%s u%0d empty", tag, k), int'(emp_v[k]), 1);
            chk($sformatf("%s u%0d almost_empty", tag, k), int'(aemp_v[k]), 1);
            chk($sformatf("%s u%0d full", tag, k), int'(full_v[k]), 0);
            chk($sformatf("%s u%0d almost_full", tag, k), int'(afull_v[k]), 0);
            chk($sformatf("%s u%0d r_valid", tag, k), int'(rv_v[k]), 0);
            chk($sformatf("%s u%0d r_data", tag, k), int'(rd_v[k]), 0);
            chk($sformatf("%s u%0d overflow", tag, k), int'(ovf_v[k]), 0);
            chk($sformatf("%s u%0d underflow", tag, k), int'(udf_v[k]), 0);
        end
    endtask

    logic [8:0] ae_tab, af_tab;

    initial begin
        ae_tab = 9'h007;   // count <= 2
        af_tab = 9'h1C0;   // count >= 6
        reset = 1'b1; flush = 0; w_incr = 0; r_incr = 0; wd = 8'h00;
        @(negedge clk); @(negedge clk);
        chk_reset("reset");
        reset = 1'b0;
        @(negedge clk);

        // Fill, drain, repeated so both pointers wrap.
        for (int rep = 0; rep < 3; rep++) begin
            for (int i = 0; i < 5; i++) step(1, 8'(8'h11 + i), 0, 0);
            chk("fill u0 full", int'(full_v[0]), 1);
            chk("fill u0 count", cnt(0), 5);
            for (int i = 0; i < 5; i++) begin
                step(0, 8'h00, 1, 0);
                chk("drain u0 r_data", int'(rd_v[0]), 8'h11 + i);
                chk("drain u0 r_valid", int'(rv_v[0]), 1);
            end
            chk("drain u0 empty", int'(emp_v[0]), 1);
        end

        // Overflow and simultaneous read+write when full.
        for (int i = 0; i < 5; i++) step(1, 8'(8'h21 + i), 0, 0);
        step(1, 8'hAA, 0, 0);
        chk("ovf u0 overflow", int'(ovf_v[0]), 1);
        chk("ovf u0 count", cnt(0), 5);
        step(1, 8'hBB, 1, 0);
        chk("full rw u0 r_data", int'(rd_v[0]), 8'h21);
        chk("full rw u0 count", cnt(0), 4);
        chk("full rw u0 overflow", int'(ovf_v[0]), 1);
        chk("full rw u2 count", cnt(2), 6);
        for (int i = 0; i < 8; i++) step(0, 8'h00, 1, 0);
        step(0, 8'h00, 0, 0);

        // Underflow and simultaneous read+write when empty (FWFT instance).
        step(0, 8'h00, 1, 0);
        chk("udf u1 underflow", int'(udf_v[1]), 1);
        step(1, 8'h3C, 1, 0);
        chk("empty rw u1 underflow", int'(udf_v[1]), 1);
        chk("empty rw u1 count", cnt(1), 1);
        chk("empty rw u1 r_data", int'(rd_v[1]), 8'h3C);
        chk("empty rw u1 r_valid", int'(rv_v[1]), 1);
        step(0, 8'h00, 1, 0);
        step(0, 8'h00, 0, 0);

        // Threshold flags on the depth-8 instance, up then down.
        for (int c = 1; c <= 8; c++) begin
            step(1, 8'(8'h60 + c), 0, 0);
            chk("thr up u2 count", cnt(2), c);
            chk("thr up u2 almost_empty", int'(aemp_v[2]), int'(ae_tab[c]));
            chk("thr up u2 almost_full", int'(afull_v[2]), int'(af_tab[c]));
        end
        for (int c = 7; c >= 0; c--) begin
            step(0, 8'h00, 1, 0);
            chk("thr dn u2 count", cnt(2), c);
            chk("thr dn u2 r_data", int'(rd_v[2]), 8'h61 + (7 - c));
            chk("thr dn u2 almost_empty", int'(aemp_v[2]), int'(ae_tab[c]));
            chk("thr dn u2 almost_full", int'(afull_v[2]), int'(af_tab[c]));
        end
        step(0, 8'h00, 1, 0);
        step(0, 8'h00, 0, 0);

        // Flush beats a simultaneous read and write.
        for (int i = 0; i < 4; i++) step(1, 8'(8'h41 + i), 0, 0);
        chk("pre-flush u0 count", cnt(0), 4);
        step(1, 8'h99, 1, 1);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("flush u%0d count", k), cnt(k), 0);
            chk($sformatf("flush u%0d empty", k), int'(emp_v[k]), 1);
            chk($sformatf("flush u%0d overflow", k), int'(ovf_v[k]), 0);
            chk($sformatf("flush u%0d underflow", k), int'(udf_v[k]), 0);
        end
        chk("flush u0 r_valid", int'(rv_v[0]), 0);
        step(1, 8'h5A, 0, 0);
        chk("post-flush u1 r_data", int'(rd_v[1]), 8'h5A);
        step(0, 8'h00, 1, 0);
        chk("post-flush u0 r_data", int'(rd_v[0]), 8'h5A);
        chk("post-flush u0 r_valid", int'(rv_v[0]), 1);

        // Asynchronous reset in the middle of streaming traffic.
        step(1, 8'h70, 0, 0);
        step(1, 8'h71, 0, 0);
        for (int i = 0; i < 4; i++) step(1, 8'(8'h72 + i), 1, 0);
        #2 reset = 1'b1;
        #1 chk_reset("async");
        #1 reset = 1'b0;
        step(1, 8'h77, 0, 0);
        chk("after reset u1 r_data", int'(rd_v[1]), 8'h77);
        chk("after reset u1 count", cnt(1), 1);
        step(0, 8'h00, 1, 0);
        chk("after reset u0 r_data", int'(rd_v[0]), 8'h77);
        chk("after reset u0 r_valid", int'(rv_v[0]), 1);
        step(0, 8'h00, 0, 0);
        step(0, 8'h00, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
